// File: rtl/test_axis_tx_gen.sv
// -----------------------------------------------------------------------------
// test_axis_tx_gen
//
// Test traffic source. Emits AXI4-Stream frames whose payload describes
// itself: the top 16 bits carry the frame sequence number (frame_cnt at the
// frame's first beat) and the low 16 bits carry the beat index. All other bits
// are zero. Frames can be fired once (start) or repeated (continuous), with a
// fixed idle gap of GAP_CYCLES cycles between frames.
//
// Ports
//   clk            : clock
//   rstn           : asynchronous active-low reset
//   start          : one-cycle frame request, only looked at in IDLE
//   continuous     : level; while high, frames repeat
//   tx_axis_tdata  : payload {seq[15:0], zeros, beat_idx[15:0]}
//   tx_axis_tkeep  : byte enables; low LAST_BYTES bits on the last beat
//   tx_axis_tvalid : beat valid
//   tx_axis_tlast  : last beat of the frame
//   tx_axis_tready : downstream ready
//   busy           : high while in SEND or GAP
//   frame_cnt      : completed frames, wraps at 16 bits
//   dbg_state      : current FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// While tvalid is high and tready low, tdata/tkeep/tlast are held and tvalid
// stays high until the transfer happens.
// -----------------------------------------------------------------------------
module test_axis_tx_gen #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int FRAME_BEATS     = 130,
    parameter int GAP_CYCLES      = 16,
    parameter int LAST_BYTES      = AXIS_DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         continuous,
    output logic [AXIS_DATA_WIDTH-1:0]   tx_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] tx_axis_tkeep,
    output logic                         tx_axis_tvalid,
    output logic                         tx_axis_tlast,
    input  logic                         tx_axis_tready,
    output logic                         busy,
    output logic [15:0]                  frame_cnt,
    output logic [1:0]                   dbg_state
);

    localparam int AW = AXIS_DATA_WIDTH;
    localparam int KW = AXIS_DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_BEATS - 1);
    // A one-beat frame starts on its own last beat.
    localparam logic        FIRST_IS_LAST = (FRAME_BEATS == 1);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]    state;
    logic [15:0]   beat_idx;
    logic [GW-1:0] gap_cnt;

    logic          handshake;
    logic          is_last_beat;
    logic [15:0]   next_idx;
    logic [15:0]   next_cnt;
    logic [15:0]   cur_seq;

    function automatic logic [KW-1:0] keep_for(input logic last);
        logic [KW-1:0] k;
        k = '1;
        if (last) begin
            for (int i = 0; i < KW; i++) begin
                k[i] = (i < LAST_BYTES);
            end
        end
        return k;
    endfunction

    function automatic logic [AW-1:0] data_for(input logic [15:0] seq, input logic [15:0] idx);
        logic [AW-1:0] d;
        d            = '0;
        d[AW-1 -: 16] = seq;
        d[15:0]      = idx;
        return d;
    endfunction

    assign handshake    = tx_axis_tvalid && tx_axis_tready;
    assign is_last_beat = (beat_idx == LAST_IDX);
    assign next_idx     = beat_idx + 16'd1;
    assign next_cnt     = frame_cnt + 16'd1;
    // The sequence number lives in the output register for the whole frame.
    assign cur_seq      = tx_axis_tdata[AW-1 -: 16];
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            beat_idx       <= '0;
            gap_cnt        <= '0;
            frame_cnt      <= '0;
            busy           <= 1'b0;
            tx_axis_tvalid <= 1'b0;
            tx_axis_tlast  <= 1'b0;
            tx_axis_tdata  <= '0;
            tx_axis_tkeep  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || continuous) begin
                        state          <= S_SEND;
                        busy           <= 1'b1;
                        beat_idx       <= '0;
                        tx_axis_tvalid <= 1'b1;
                        tx_axis_tdata  <= data_for(frame_cnt, 16'd0);
                        tx_axis_tlast  <= FIRST_IS_LAST;
                        tx_axis_tkeep  <= keep_for(FIRST_IS_LAST);
                    end
                end

                S_SEND: begin
                    if (handshake) begin
                        if (is_last_beat) begin
                            frame_cnt <= next_cnt;
                            beat_idx  <= '0;
                            if (GAP_CYCLES > 0) begin
                                state          <= S_GAP;
                                gap_cnt        <= '0;
                                tx_axis_tvalid <= 1'b0;
                                tx_axis_tlast  <= 1'b0;
                                tx_axis_tdata  <= '0;
                                tx_axis_tkeep  <= '0;
                            end else if (continuous) begin
                                // No gap: next frame's first beat follows directly.
                                tx_axis_tdata <= data_for(next_cnt, 16'd0);
                                tx_axis_tlast <= FIRST_IS_LAST;
                                tx_axis_tkeep <= keep_for(FIRST_IS_LAST);
                            end else begin
                                state          <= S_IDLE;
                                busy           <= 1'b0;
                                tx_axis_tvalid <= 1'b0;
                                tx_axis_tlast  <= 1'b0;
                                tx_axis_tdata  <= '0;
                                tx_axis_tkeep  <= '0;
                            end
                        end else begin
                            beat_idx      <= next_idx;
                            tx_axis_tdata <= data_for(cur_seq, next_idx);
                            tx_axis_tlast <= (next_idx == LAST_IDX);
                            tx_axis_tkeep <= keep_for(next_idx == LAST_IDX);
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (continuous) begin
                            state          <= S_SEND;
                            tx_axis_tvalid <= 1'b1;
                            tx_axis_tdata  <= data_for(frame_cnt, 16'd0);
                            tx_axis_tlast  <= FIRST_IS_LAST;
                            tx_axis_tkeep  <= keep_for(FIRST_IS_LAST);
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    busy           <= 1'b0;
                    tx_axis_tvalid <= 1'b0;
                    tx_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_axis_tx_gen.sv
// -----------------------------------------------------------------------------
// Directed bench for test_axis_tx_gen. Three instances:
//   u0 : defaults (130 beats, 16-cycle gap, full keep)
//   u1 : GAP_CYCLES=4, continuous frames
//   u2 : GAP_CYCLES=0, FRAME_BEATS=1, LAST_BYTES=3, continuous
// Outputs are sampled 1 time unit after the rising edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_test_axis_tx_gen;

    logic clk;
    logic rstn;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- u0 ----------------
    logic        start0, cont0, tready0;
    logic [63:0] tdata0;
    logic [7:0]  tkeep0;
    logic        tvalid0, tlast0, busy0;
    logic [15:0] fcnt0;
    logic [1:0]  st0;

    test_axis_tx_gen u0 (
        .clk(clk), .rstn(rstn), .start(start0), .continuous(cont0),
        .tx_axis_tdata(tdata0), .tx_axis_tkeep(tkeep0), .tx_axis_tvalid(tvalid0),
        .tx_axis_tlast(tlast0), .tx_axis_tready(tready0), .busy(busy0),
        .frame_cnt(fcnt0), .dbg_state(st0)
    );

    // ---------------- u1 ----------------
    logic        start1, cont1, tready1;
    logic [63:0] tdata1;
    logic [7:0]  tkeep1;
    logic        tvalid1, tlast1, busy1;
    logic [15:0] fcnt1;
    logic [1:0]  st1;

    test_axis_tx_gen #(.GAP_CYCLES(4)) u1 (
        .clk(clk), .rstn(rstn), .start(start1), .continuous(cont1),
        .tx_axis_tdata(tdata1), .tx_axis_tkeep(tkeep1), .tx_axis_tvalid(tvalid1),
        .tx_axis_tlast(tlast1), .tx_axis_tready(tready1), .busy(busy1),
        .frame_cnt(fcnt1), .dbg_state(st1)
    );

    // ---------------- u2 ----------------
    logic        start2, cont2, tready2;
    logic [63:0] tdata2;
    logic [7:0]  tkeep2;
    logic        tvalid2, tlast2, busy2;
    logic [15:0] fcnt2;
    logic [1:0]  st2;

    test_axis_tx_gen #(.GAP_CYCLES(0), .FRAME_BEATS(1), .LAST_BYTES(3)) u2 (
        .clk(clk), .rstn(rstn), .start(start2), .continuous(cont2),
        .tx_axis_tdata(tdata2), .tx_axis_tkeep(tkeep2), .tx_axis_tvalid(tvalid2),
        .tx_axis_tlast(tlast2), .tx_axis_tready(tready2), .busy(busy2),
        .frame_cnt(fcnt2), .dbg_state(st2)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] exp_data(input int seq, input int idx);
        logic [15:0] s;
        logic [15:0] b;
        s = 16'(seq);
        b = 16'(idx);
        return {s, 32'h0, b};
    endfunction

    // Receive one 130-beat frame from u0, starting with beat 0 already visible.
    // bp   : pseudo-random tready with a 10-cycle stall on the last beat
    // poke : pulse start at beat 60 (must be ignored)
    task automatic recv_frame_u0(input int seq, input bit bp, input bit poke);
        int          idx;
        int          cyc;
        int          hold;
        bit          prev_stall;
        bit          poked;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        idx = 0; cyc = 0; hold = 0; prev_stall = 0; poked = 0;
        pd = '0; pk = '0; pl = 1'b0;
        while (idx < 130 && cyc < 3000) begin
            check("u0_tvalid", tvalid0, 1);
            if (!tvalid0) break;
            check("u0_tdata", tdata0, exp_data(seq, idx));
            check("u0_tlast", tlast0, (idx == 129));
            check("u0_tkeep", tkeep0, 8'hFF);
            if (prev_stall) begin
                check("u0_stall_tdata", tdata0, pd);
                check("u0_stall_tkeep", tkeep0, pk);
                check("u0_stall_tlast", tlast0, pl);
            end
            if (!bp) begin
                tready0 = 1'b1;
            end else if (idx == 129 && hold < 10) begin
                tready0 = 1'b0;
                hold++;
            end else begin
                tready0 = 1'($urandom_range(0, 1));
            end
            prev_stall = !tready0;
            pd = tdata0; pk = tkeep0; pl = tlast0;
            if (tready0) idx++;
            if (poke && idx == 60 && !poked) begin
                start0 = 1'b1;
                poked  = 1'b1;
            end
            tick();
            start0 = 1'b0;
            cyc++;
        end
        check("u0_frame_beats", 64'(idx), 64'd130);
        tready0 = 1'b1;
    endtask

    // Walk u0 through its gap; optionally pulse start mid-gap.
    task automatic gap_u0(input int n, input bit poke);
        for (int g = 0; g < n; g++) begin
            check("u0_gap_tvalid", tvalid0, 0);
            check("u0_gap_busy", busy0, 1);
            if (poke && g == 5) start0 = 1'b1;
            tick();
            start0 = 1'b0;
        end
        check("u0_idle_busy", busy0, 0);
        check("u0_idle_tvalid", tvalid0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lowcnt;

        rstn = 1'b0;
        start0 = 0; cont0 = 0; tready0 = 1;
        start1 = 0; cont1 = 0; tready1 = 1;
        start2 = 0; cont2 = 0; tready2 = 1;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset state
        check("rst_tvalid", tvalid0, 0);
        check("rst_tlast", tlast0, 0);
        check("rst_tdata", tdata0, 0);
        check("rst_tkeep", tkeep0, 0);
        check("rst_busy", busy0, 0);
        check("rst_frame_cnt", fcnt0, 0);
        check("rst_state", st0, 0);

        // Single frame, tready=1
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        recv_frame_u0(0, 0, 0);
        check("f0_frame_cnt", fcnt0, 1);
        gap_u0(16, 0);

        // Back-pressure frame
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        recv_frame_u0(1, 1, 0);
        check("f1_frame_cnt", fcnt0, 2);
        gap_u0(16, 0);

        // start pulsed during SEND and GAP: ignored
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        recv_frame_u0(2, 0, 1);
        check("f2_frame_cnt", fcnt0, 3);
        gap_u0(16, 1);
        repeat (20) tick();
        check("poke_tvalid", tvalid0, 0);
        check("poke_busy", busy0, 0);
        check("poke_frame_cnt", fcnt0, 3);

        // Reset at beat 50
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (50) tick();
        check("pre_rst_tdata", tdata0, exp_data(3, 50));
        #2;
        rstn = 1'b0;
        #1;
        check("arst_tvalid", tvalid0, 0);
        check("arst_tlast", tlast0, 0);
        check("arst_tdata", tdata0, 0);
        check("arst_tkeep", tkeep0, 0);
        check("arst_busy", busy0, 0);
        check("arst_frame_cnt", fcnt0, 0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        check("post_rst_tvalid", tvalid0, 0);
        check("post_rst_busy", busy0, 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        recv_frame_u0(0, 0, 0);
        check("post_rst_frame_cnt", fcnt0, 1);
        gap_u0(16, 0);

        // u1: continuous, GAP_CYCLES=4, three frames
        cont1 = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 130; b++) begin
                check("u1_tvalid", tvalid1, 1);
                check("u1_tdata", tdata1, exp_data(f, b));
                check("u1_tlast", tlast1, (b == 129));
                tick();
            end
            check("u1_frame_cnt", fcnt1, 64'(f + 1));
            if (f == 2) cont1 = 1'b0;
            lowcnt = 0;
            while (!tvalid1 && lowcnt < 20) begin
                lowcnt++;
                tick();
            end
            if (f < 2) check("u1_gap_len", 64'(lowcnt), 64'd4);
        end
        check("u1_end_busy", busy1, 0);
        check("u1_end_tvalid", tvalid1, 0);
        check("u1_end_frame_cnt", fcnt1, 3);

        // u2: GAP=0, one-beat frames, LAST_BYTES=3, continuous
        cont2 = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("u2_tvalid", tvalid2, 1);
            check("u2_tlast", tlast2, 1);
            check("u2_tkeep", tkeep2, 8'h07);
            check("u2_tdata", tdata2, exp_data(k, 0));
            tick();
        end
        check("u2_frame_cnt8", fcnt2, 8);
        check("u2_tdata8", tdata2, exp_data(8, 0));
        cont2 = 1'b0;
        tick();
        check("u2_frame_cnt9", fcnt2, 9);
        check("u2_stop_tvalid", tvalid2, 0);
        check("u2_stop_busy", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/test_axis_tx_gen.md
# test_axis_tx_gen

Test traffic source for the Ethernet control path: emits AXI4-Stream frames with a deterministic, self-describing payload (frame sequence number plus beat index) toward the RX-side test sink or MAC TX path. Honours `tready` back-pressure and inserts a programmable idle gap between frames. Supports a single-shot or continuous mode, so the downstream sink can check frame length, ordering and data integrity.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 64: stream width in bits; multiple of 8, minimum 32.
- `FRAME_BEATS`, 130: beats per frame; range 1..65535.
- `GAP_CYCLES`, 16: idle cycles between frames with `tvalid` low; 0 allowed.
- `LAST_BYTES`, `AXIS_DATA_WIDTH/8`: valid bytes in the final beat; range 1..`AXIS_DATA_WIDTH/8`.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `continuous` in 1: level. While high, frames repeat indefinitely.
- `tx_axis_tdata` out `AXIS_DATA_WIDTH`: payload.
- `tx_axis_tkeep` out `AXIS_DATA_WIDTH/8`: byte enables.
- `tx_axis_tvalid` out 1: beat valid.
- `tx_axis_tlast` out 1: final beat of frame.
- `tx_axis_tready` in 1: downstream ready.
- `busy` out 1: high in SEND or GAP.
- `frame_cnt` out 16: completed frames; wraps 0xFFFF -> 0.

## Operation
- All outputs are registered.
- Reset values: `tvalid`=0, `tlast`=0, `tdata`=0, `tkeep`=0, `busy`=0, `frame_cnt`=0. Internal state: FSM=IDLE, `beat_idx`=0, gap counter=0.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - Moves to SEND when `start` or `continuous` is high.
  - `start` is ignored in SEND and GAP. It is not queued.
- SEND:
  - `tvalid`=1.
  - A beat transfers on `tvalid && tready`. Each transfer increments `beat_idx`.
- Beat contents:
  - `tdata[AW-1:AW-16]` = `frame_cnt` at the frame's first beat, held for the whole frame.
  - `tdata[15:0]` = `beat_idx`.
  - All other bits are 0.
  - `tkeep` = all ones, except on the last beat: low `LAST_BYTES` bits set.
  - `tlast`=1 only when `beat_idx == FRAME_BEATS-1`.
- On the last-beat transfer:
  - `frame_cnt` increments and `beat_idx` clears.
  - If `GAP_CYCLES`>0: go to GAP.
  - If `GAP_CYCLES`=0: go to SEND if `continuous`=1, else IDLE.
- GAP:
  - `tvalid`=0. Counts `GAP_CYCLES` cycles.
  - Then goes to SEND if `continuous`=1, else IDLE.
  - `continuous` is sampled on the final gap cycle.
- `continuous` falling mid-frame never truncates a frame. The frame completes, then the block returns to IDLE after the gap.
- AXIS rule: while `tvalid && !tready`, `tdata`, `tkeep` and `tlast` hold stable and `tvalid` does not drop.
- `busy` = (state != IDLE). It falls in the cycle the block re-enters IDLE.
- Reset asserted mid-frame aborts immediately: `tvalid` drops asynchronously. After release the block is in IDLE and there is no partial-frame resume.

## Timing
- Start latency: `start` high at edge N in IDLE gives `tvalid`=1, `beat_idx`=0 visible after edge N.
- Back-to-back beats when `tready`=1: one beat per cycle. A frame occupies exactly `FRAME_BEATS` cycles when unstalled.
- Gap length: last handshake at edge E; `tvalid` is low for exactly `GAP_CYCLES` cycles; the next frame's first beat is valid after edge E+`GAP_CYCLES`.
- With `GAP_CYCLES`=0 and `continuous`=1, `tvalid` stays high across the frame boundary.
- `frame_cnt` updates in the same edge as the last-beat handshake.

## Test plan
- Single frame, defaults, `tready`=1, pulse `start`:
  - 130 beats; `tdata[15:0]` = 0..129, upper 16 bits = 0.
  - `tlast` only on beat 129, `tkeep`=0xFF.
  - Then `frame_cnt`=1; `busy` low after 16 gap cycles.
- Back-pressure: `tready` toggles pseudo-randomly, including a 10-cycle low on the last beat:
  - No beat lost or duplicated.
  - Outputs stable during every stall.
  - Beat indices contiguous 0..129.
- Continuous mode, `GAP_CYCLES`=4, 3 frames:
  - Upper `tdata` = 0, 1, 2.
  - Exactly 4 `tvalid`-low cycles between frames.
  - `frame_cnt`=3 after the third `tlast`.
- `GAP_CYCLES`=0, `FRAME_BEATS`=1, `LAST_BYTES`=3, continuous:
  - Every beat has `tlast`=1 and `tkeep`=0x07.
  - `tvalid` continuously high.
- `start` pulsed during SEND and during GAP (single-shot mode): ignored; only one frame produced.
- `rstn` low at beat 50:
  - All outputs return to reset values without waiting for a clock.
  - After release, a new `start` yields a frame from beat 0 with `frame_cnt`=0.
